// File: rtl/check_collision.sv
// Maze collision checker: registers whether a one-pixel step from (PacX, PacY)
// in direction `state` lands on a clear point, plus a free-running pacing divider.
module check_collision (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  PacX,
    input  logic [8:0]  PacY,
    input  logic [1:0]  state,
    output logic        result,
    output logic [31:0] clkdiv
);
    localparam int NUM_BLK = 5;

    // Interior walls, index 0..4 = A..E; bounds inclusive and already
    // inflated by the sprite half-size so only the centre point is tested.
    localparam logic [NUM_BLK-1:0][9:0] XLO = {10'd270, 10'd420, 10'd120, 10'd420, 10'd120};
    localparam logic [NUM_BLK-1:0][9:0] XHI = {10'd370, 10'd520, 10'd220, 10'd520, 10'd220};
    localparam logic [NUM_BLK-1:0][8:0] YLO = {9'd200, 9'd300, 9'd300, 9'd100, 9'd100};
    localparam logic [NUM_BLK-1:0][8:0] YHI = {9'd280, 9'd380, 9'd380, 9'd180, 9'd180};

    logic [9:0]         nx;
    logic [8:0]         ny;
    logic [NUM_BLK-1:0] hit;
    logic               edge_hit;
    logic               blocked;

    // Modular step: 0-1 wraps to 1023/511, which the boundary test rejects.
    always_comb begin
        nx = PacX;
        ny = PacY;
        case (state)
            2'b00: ny = PacY - 9'd1;
            2'b01: ny = PacY + 9'd1;
            2'b10: nx = PacX - 10'd1;
            2'b11: nx = PacX + 10'd1;
            default: ;
        endcase
    end

    for (genvar g = 0; g < NUM_BLK; g++) begin : g_blk
        assign hit[g] = (nx >= XLO[g]) && (nx <= XHI[g]) &&
                        (ny >= YLO[g]) && (ny <= YHI[g]);
    end

    assign edge_hit = (nx < 10'd20) || (nx > 10'd620) || (ny < 9'd20) || (ny > 9'd460);
    assign blocked  = edge_hit | (|hit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result <= 1'b1;
            clkdiv <= 32'd0;
        end else begin
            result <= ~blocked;
            clkdiv <= clkdiv + 32'd1;
        end
    end
endmodule

// File: tb/tb_check_collision.sv
// Scoreboard bench for check_collision: driver pushes expected results from a
// rectangle-table reference model, a monitor pops and compares after each edge.
module tb_check_collision;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  PacX = '0;
    logic [8:0]  PacY = '0;
    logic [1:0]  state = '0;
    logic        result;
    logic [31:0] clkdiv;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    bit exp_q[$];
    bit mon_e;

    check_collision dut (
        .clk(clk), .rst(rst), .PacX(PacX), .PacY(PacY),
        .state(state), .result(result), .clkdiv(clkdiv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: walls as a table of inclusive rectangles, integer arithmetic.
    int wx0[5] = '{120, 420, 120, 420, 270};
    int wx1[5] = '{220, 520, 220, 520, 370};
    int wy0[5] = '{100, 100, 300, 300, 200};
    int wy1[5] = '{180, 180, 380, 380, 280};

    function automatic bit model_clear(input int x, input int y, input int s);
        int nx = x, ny = y;
        if (s == 0) ny = (y + 511) % 512;
        if (s == 1) ny = (y + 1) % 512;
        if (s == 2) nx = (x + 1023) % 1024;
        if (s == 3) nx = (x + 1) % 1024;
        if (nx < 20 || nx > 620 || ny < 20 || ny > 460) return 1'b0;
        for (int i = 0; i < 5; i++)
            if (nx >= wx0[i] && nx <= wx1[i] && ny >= wy0[i] && ny <= wy1[i]) return 1'b0;
        return 1'b1;
    endfunction

    // exp < 0 means "take the model's answer"; otherwise a hand-derived constant.
    task automatic step(input int x, input int y, input int s, input int exp);
        @(negedge clk);
        PacX  = 10'(x);
        PacY  = 9'(y);
        state = 2'(s);
        exp_q.push_back(exp < 0 ? model_clear(x, y, s) : (exp != 0));
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("result", result, mon_e);
        end
    end

    int edges_x[10] = '{0, 20, 120, 220, 270, 370, 420, 520, 620, 1023};
    int edges_y[8]  = '{0, 20, 100, 180, 200, 300, 380, 460};

    initial begin
        int x, y;
        // Reset and counting
        #12;
        chk("rst_result", result, 1);
        chk("rst_clkdiv", clkdiv, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            chk("clkdiv_bit3", clkdiv[3], (i >= 8));
        end
        chk("clkdiv_10", clkdiv, 10);

        // Directed scenarios through the scoreboard
        mon_en = 1'b1;
        step(595, 435, 2, 1);
        step(620, 435, 3, 0);
        step(20, 240, 2, 0);
        step(20, 240, 3, 1);
        step(20, 240, 0, 1);
        step(221, 140, 2, 0);
        step(221, 140, 0, 1);
        step(170, 99, 1, 0);
        step(300, 0, 0, 0);
        step(0, 240, 2, 0);

        // Randomized, biased toward wall edges
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 1) == 0)
                x = (edges_x[$urandom_range(0, 9)] + int'($urandom_range(0, 4)) - 2 + 1024) % 1024;
            else
                x = $urandom_range(0, 1023);
            if ($urandom_range(0, 1) == 0)
                y = (edges_y[$urandom_range(0, 7)] + int'($urandom_range(0, 4)) - 2 + 512) % 512;
            else
                y = $urandom_range(0, 511);
            step(x, y, $urandom_range(0, 3), -1);
        end
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        mon_en = 1'b0;

        // Divider wrap
        @(negedge clk);
        force dut.clkdiv = 32'hFFFF_FFFF;
        #1;
        release dut.clkdiv;
        @(posedge clk);
        #1;
        chk("clkdiv_wrap", clkdiv, 0);

        // Asynchronous reset between edges while blocked and counting
        @(negedge clk);
        PacX = 10'd20; PacY = 9'd240; state = 2'b10;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_result", result, 0);
        chk("pre_rst_nonzero", (clkdiv != 0), 1);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_result", result, 1);
        chk("async_rst_clkdiv", clkdiv, 0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_clkdiv", clkdiv, 1);
        chk("post_rst_result", result, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1, "timeout");
    end
endmodule
